// File: rtl/noc_pyld_ctxt_mux.sv
// Packet-atomic N:1 merge of AXI-Stream context/payload pairs.
// Each grant forwards one context packet, then its payload packet.
// Round-robin arbitration runs over a per-port enable mask.
// Completed packets are counted per port.
module noc_pyld_ctxt_mux #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned CHDR_W    = 64,
  parameter int unsigned ITEM_W    = 32,
  parameter int unsigned NIPC      = 1,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned PYLD_W   = ITEM_W * NIPC,
  localparam int unsigned PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          axis_data_clk,
  input  logic                          axis_data_rst,
  input  logic [NUM_PORTS*PYLD_W-1:0]   s_payload_tdata,
  input  logic [NUM_PORTS*NIPC-1:0]     s_payload_tkeep,
  input  logic [NUM_PORTS-1:0]          s_payload_tlast,
  input  logic [NUM_PORTS-1:0]          s_payload_tvalid,
  output logic [NUM_PORTS-1:0]          s_payload_tready,
  input  logic [NUM_PORTS*CHDR_W-1:0]   s_context_tdata,
  input  logic [NUM_PORTS*4-1:0]        s_context_tuser,
  input  logic [NUM_PORTS-1:0]          s_context_tlast,
  input  logic [NUM_PORTS-1:0]          s_context_tvalid,
  output logic [NUM_PORTS-1:0]          s_context_tready,
  output logic [PYLD_W-1:0]             m_payload_tdata,
  output logic [NIPC-1:0]               m_payload_tkeep,
  output logic                          m_payload_tlast,
  output logic                          m_payload_tvalid,
  input  logic                          m_payload_tready,
  output logic [CHDR_W-1:0]             m_context_tdata,
  output logic [3:0]                    m_context_tuser,
  output logic                          m_context_tlast,
  output logic                          m_context_tvalid,
  input  logic                          m_context_tready,
  input  logic [NUM_PORTS-1:0]          port_enable,
  output logic [PORT_W-1:0]             active_port,
  output logic [NUM_PORTS*CNT_W-1:0]    pkt_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, CTXT = 2'd1, PYLD = 2'd2} state_t;

  state_t                              state, state_nxt;
  logic [PORT_W-1:0]                   rr_ptr;
  logic [PORT_W-1:0]                   grant;
  logic [PORT_W-1:0]                   idx;
  logic                                grant_found;
  logic [NUM_PORTS-1:0]                req;
  logic [NUM_PORTS-1:0]                sel;
  logic                                pkt_done;
  logic [NUM_PORTS-1:0][CNT_W-1:0]     cnt;

  logic [CHDR_W-1:0]                   sel_ctx_data;
  logic [3:0]                          sel_ctx_user;
  logic                                sel_ctx_last;
  logic                                sel_ctx_valid;
  logic [PYLD_W-1:0]                   sel_pay_data;
  logic [NIPC-1:0]                     sel_pay_keep;
  logic                                sel_pay_last;
  logic                                sel_pay_valid;

  // Round-robin search: first requesting port at or after rr_ptr, with wrap
  always_comb begin
    req         = s_context_tvalid & port_enable;
    grant_found = 1'b0;
    grant       = '0;
    idx         = rr_ptr;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!grant_found && req[idx]) begin
        grant_found = 1'b1;
        grant       = idx;
      end
      idx = (idx == PORT_W'(NUM_PORTS - 1)) ? '0 : idx + PORT_W'(1);
    end
  end

  // One-hot decode of the granted port and mux of its streams
  always_comb begin
    sel           = '0;
    sel_ctx_data  = '0;
    sel_ctx_user  = '0;
    sel_ctx_last  = 1'b0;
    sel_ctx_valid = 1'b0;
    sel_pay_data  = '0;
    sel_pay_keep  = '0;
    sel_pay_last  = 1'b0;
    sel_pay_valid = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (active_port == PORT_W'(p)) begin
        sel[p]        = 1'b1;
        sel_ctx_data  = s_context_tdata[p*CHDR_W +: CHDR_W];
        sel_ctx_user  = s_context_tuser[p*4 +: 4];
        sel_ctx_last  = s_context_tlast[p];
        sel_ctx_valid = s_context_tvalid[p];
        sel_pay_data  = s_payload_tdata[p*PYLD_W +: PYLD_W];
        sel_pay_keep  = s_payload_tkeep[p*NIPC +: NIPC];
        sel_pay_last  = s_payload_tlast[p];
        sel_pay_valid = s_payload_tvalid[p];
      end
    end
  end

  // Next state and handshake steering; only the granted port sees ready
  always_comb begin
    state_nxt        = state;
    pkt_done         = 1'b0;
    s_context_tready = '0;
    s_payload_tready = '0;
    m_context_tvalid = 1'b0;
    m_payload_tvalid = 1'b0;
    m_context_tdata  = sel_ctx_data;
    m_context_tuser  = sel_ctx_user;
    m_context_tlast  = sel_ctx_last;
    m_payload_tdata  = sel_pay_data;
    m_payload_tkeep  = sel_pay_keep;
    m_payload_tlast  = sel_pay_last;
    case (state)
      IDLE: begin
        if (grant_found) state_nxt = CTXT;
      end
      CTXT: begin
        m_context_tvalid = sel_ctx_valid;
        s_context_tready = sel & {NUM_PORTS{m_context_tready}};
        if (sel_ctx_valid && m_context_tready && sel_ctx_last) state_nxt = PYLD;
      end
      PYLD: begin
        m_payload_tvalid = sel_pay_valid;
        s_payload_tready = sel & {NUM_PORTS{m_payload_tready}};
        if (sel_pay_valid && m_payload_tready && sel_pay_last) begin
          pkt_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant, round-robin pointer and packet counters
  always_ff @(posedge axis_data_clk) begin
    if (axis_data_rst) begin
      state       <= IDLE;
      active_port <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_found) active_port <= grant;
      if (pkt_done) begin
        rr_ptr <= (active_port == PORT_W'(NUM_PORTS - 1)) ? '0 : active_port + PORT_W'(1);
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
          if (sel[p]) cnt[p] <= cnt[p] + CNT_W'(1);
        end
      end
    end
  end

  assign pkt_count = cnt;

endmodule

// File: tb/tb_noc_pyld_ctxt_mux.sv
// Scoreboard bench for noc_pyld_ctxt_mux: per-port packet sources, a
// transaction-level arbitration model and a negedge monitor.
module tb_noc_pyld_ctxt_mux;
  localparam int unsigned NP = 4, CW = 64, IW = 32, NIPC = 1, CNTW = 2, APW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NP*IW-1:0]     s_payload_tdata;
  logic [NP*NIPC-1:0]   s_payload_tkeep;
  logic [NP-1:0]        s_payload_tlast, s_payload_tvalid, s_payload_tready;
  logic [NP*CW-1:0]     s_context_tdata;
  logic [NP*4-1:0]      s_context_tuser;
  logic [NP-1:0]        s_context_tlast, s_context_tvalid, s_context_tready;
  logic [IW-1:0]        m_payload_tdata;
  logic [NIPC-1:0]      m_payload_tkeep;
  logic                 m_payload_tlast, m_payload_tvalid, m_payload_tready;
  logic [CW-1:0]        m_context_tdata;
  logic [3:0]           m_context_tuser;
  logic                 m_context_tlast, m_context_tvalid, m_context_tready;
  logic [NP-1:0]        port_enable;
  logic [APW-1:0]       active_port;
  logic [NP*CNTW-1:0]   pkt_count;

  noc_pyld_ctxt_mux #(.NUM_PORTS(NP), .CHDR_W(CW), .ITEM_W(IW), .NIPC(NIPC), .CNT_W(CNTW)) dut (
    .axis_data_clk(clk), .axis_data_rst(rst),
    .s_payload_tdata(s_payload_tdata), .s_payload_tkeep(s_payload_tkeep),
    .s_payload_tlast(s_payload_tlast), .s_payload_tvalid(s_payload_tvalid),
    .s_payload_tready(s_payload_tready),
    .s_context_tdata(s_context_tdata), .s_context_tuser(s_context_tuser),
    .s_context_tlast(s_context_tlast), .s_context_tvalid(s_context_tvalid),
    .s_context_tready(s_context_tready),
    .m_payload_tdata(m_payload_tdata), .m_payload_tkeep(m_payload_tkeep),
    .m_payload_tlast(m_payload_tlast), .m_payload_tvalid(m_payload_tvalid),
    .m_payload_tready(m_payload_tready),
    .m_context_tdata(m_context_tdata), .m_context_tuser(m_context_tuser),
    .m_context_tlast(m_context_tlast), .m_context_tvalid(m_context_tvalid),
    .m_context_tready(m_context_tready),
    .port_enable(port_enable), .active_port(active_port), .pkt_count(pkt_count)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  aux;
    logic        last;
  } beat_t;

  beat_t ctx_q[NP][$];
  beat_t pay_q[NP][$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus knobs
  logic [NP-1:0] gen_en;
  int gen_pct, gap_pct, lenc, lenp, cready_mode, pready_mode;

  // Source state per port
  bit    busy_s[NP];
  int    cidx[NP], pidx[NP], clen[NP], plen[NP];
  beat_t cbeat[NP][4];
  beat_t pbeat[NP][8];
  logic [NP-1:0] hs_c, hs_p;

  task automatic new_pkt(input int p);
    beat_t b;
    clen[p] = (lenc != 0) ? lenc : int'($urandom_range(1, 3));
    plen[p] = (lenp != 0) ? lenp : int'($urandom_range(1, 8));
    for (int i = 0; i < clen[p]; i++) begin
      b.data = {$urandom, $urandom};
      b.aux  = 4'($urandom);
      b.last = (i == clen[p] - 1);
      cbeat[p][i] = b;
      ctx_q[p].push_back(b);
    end
    for (int i = 0; i < plen[p]; i++) begin
      b.data = {32'h0, $urandom};
      b.aux  = 4'($urandom_range(0, 1));
      b.last = (i == plen[p] - 1);
      pbeat[p][i] = b;
      pay_q[p].push_back(b);
    end
    cidx[p] = 0;
    pidx[p] = 0;
    busy_s[p] = 1'b1;
  endtask

  // Sources and sink readies: advance on handshakes seen at negedge, redrive after posedge
  initial begin
    s_context_tvalid = '0; s_context_tdata = '0; s_context_tuser = '0; s_context_tlast = '0;
    s_payload_tvalid = '0; s_payload_tdata = '0; s_payload_tkeep = '0; s_payload_tlast = '0;
    m_context_tready = 1'b0; m_payload_tready = 1'b0;
    for (int p = 0; p < NP; p++) begin
      busy_s[p] = 1'b0; cidx[p] = 0; pidx[p] = 0; clen[p] = 0; plen[p] = 0;
    end
    forever begin
      @(negedge clk);
      hs_c = s_context_tvalid & s_context_tready;
      hs_p = s_payload_tvalid & s_payload_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (rst) begin
          busy_s[p] = 1'b0;
        end else begin
          if (hs_c[p]) cidx[p]++;
          if (hs_p[p]) pidx[p]++;
          if (busy_s[p] && cidx[p] >= clen[p] && pidx[p] >= plen[p]) busy_s[p] = 1'b0;
          if (!busy_s[p] && gen_en[p] && int'($urandom_range(99)) < gen_pct) new_pkt(p);
        end
        if (busy_s[p] && cidx[p] < clen[p] && int'($urandom_range(99)) >= gap_pct) begin
          s_context_tvalid[p]          = 1'b1;
          s_context_tdata[p*CW +: CW]  = cbeat[p][cidx[p]].data;
          s_context_tuser[p*4 +: 4]    = cbeat[p][cidx[p]].aux;
          s_context_tlast[p]           = cbeat[p][cidx[p]].last;
        end else begin
          s_context_tvalid[p]          = 1'b0;
          s_context_tdata[p*CW +: CW]  = {$urandom, $urandom};
          s_context_tuser[p*4 +: 4]    = 4'($urandom);
          s_context_tlast[p]           = 1'($urandom);
        end
        if (busy_s[p] && pidx[p] < plen[p] && int'($urandom_range(99)) >= gap_pct) begin
          s_payload_tvalid[p]          = 1'b1;
          s_payload_tdata[p*IW +: IW]  = pbeat[p][pidx[p]].data[IW-1:0];
          s_payload_tkeep[p]           = pbeat[p][pidx[p]].aux[0];
          s_payload_tlast[p]           = pbeat[p][pidx[p]].last;
        end else begin
          s_payload_tvalid[p]          = 1'b0;
          s_payload_tdata[p*IW +: IW]  = $urandom;
          s_payload_tkeep[p]           = 1'($urandom);
          s_payload_tlast[p]           = 1'($urandom);
        end
      end
      m_context_tready = (cready_mode == 0) ? 1'b1 : 1'($urandom);
      case (pready_mode)
        0:       m_payload_tready = 1'b1;
        1:       m_payload_tready = ~m_payload_tready;
        default: m_payload_tready = 1'($urandom);
      endcase
    end
  end

  // Reference model: 0 idle, 1 forwarding context, 2 forwarding payload
  int mphase = 0, mg = 0, rr_m = 0, ap_m = 0, pkts_done = 0;
  int cnt_m[NP];
  int grant_log[$];
  bit first_c = 1'b0;
  bit found;
  logic [NP-1:0]      m_req, exp_cr, exp_pr;
  logic [NP*CNTW-1:0] exp_cnt;
  beat_t              mb;

  // Monitor: compare every cycle at negedge, pop expected beats on handshakes
  initial begin
    for (int p = 0; p < NP; p++) cnt_m[p] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mphase = 0; mg = 0; rr_m = 0; ap_m = 0; first_c = 1'b0;
        for (int p = 0; p < NP; p++) begin
          cnt_m[p] = 0;
          ctx_q[p].delete();
          pay_q[p].delete();
        end
      end else begin
        for (int p = 0; p < NP; p++) exp_cnt[p*CNTW +: CNTW] = CNTW'(cnt_m[p]);
        chk("pkt_count", 80'(pkt_count), 80'(exp_cnt));
        chk("active_port", 80'(active_port), 80'(ap_m));
        if (first_c) begin
          grant_log.push_back(int'(active_port));
          first_c = 1'b0;
        end
        case (mphase)
          0: begin
            chk("idle_outputs",
                80'({m_context_tvalid, m_payload_tvalid, s_context_tready, s_payload_tready}), 80'(0));
            m_req = s_context_tvalid & port_enable;
            found = 1'b0;
            for (int i = 0; i < NP; i++) begin
              if (!found && m_req[(rr_m + i) % NP]) begin
                found = 1'b1;
                mg = (rr_m + i) % NP;
              end
            end
            if (found) begin
              ap_m = mg; mphase = 1; first_c = 1'b1;
            end
          end
          1: begin
            exp_cr = m_context_tready ? (NP'(1) << mg) : '0;
            chk("ctxt_ctrl",
                80'({m_context_tvalid, m_payload_tvalid, s_context_tready, s_payload_tready}),
                80'({s_context_tvalid[mg], 1'b0, exp_cr, 4'b0}));
            if (s_context_tvalid[mg] && m_context_tready) begin
              if (ctx_q[mg].size() == 0) begin
                total++; bad++;
                $display("FAIL ctxt_queue: got beat on port %0d expected none", mg);
              end else begin
                mb = ctx_q[mg].pop_front();
                chk("ctxt_beat", 80'({m_context_tdata, m_context_tuser, m_context_tlast}),
                    80'({mb.data, mb.aux, mb.last}));
                if (mb.last) mphase = 2;
              end
            end
          end
          default: begin
            exp_pr = m_payload_tready ? (NP'(1) << mg) : '0;
            chk("pyld_ctrl",
                80'({m_context_tvalid, m_payload_tvalid, s_context_tready, s_payload_tready}),
                80'({1'b0, s_payload_tvalid[mg], 4'b0, exp_pr}));
            if (s_payload_tvalid[mg] && m_payload_tready) begin
              if (pay_q[mg].size() == 0) begin
                total++; bad++;
                $display("FAIL pyld_queue: got beat on port %0d expected none", mg);
              end else begin
                mb = pay_q[mg].pop_front();
                chk("pyld_beat", 80'({m_payload_tdata, m_payload_tkeep, m_payload_tlast}),
                    80'({mb.data[IW-1:0], mb.aux[0], mb.last}));
                if (mb.last) begin
                  cnt_m[mg] = (cnt_m[mg] + 1) % (1 << CNTW);
                  rr_m = (mg + 1) % NP;
                  mphase = 0;
                  pkts_done++;
                end
              end
            end
          end
        endcase
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic setup(input logic [NP-1:0] en, input logic [NP-1:0] gen,
                       input int lc, input int lp, input int pmode);
    port_enable = en; gen_en = gen; lenc = lc; lenp = lp;
    pready_mode = pmode; cready_mode = 0; gen_pct = 100; gap_pct = 0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    pkts_done = 0;
    grant_log.delete();
  endtask

  task automatic wait_pkts(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (pkts_done < n && k < budget) begin
      cyc(1);
      k++;
    end
    chk(name, 80'(pkts_done >= n), 80'(1));
  endtask

  task automatic wait_phase(input int ph, input int port, input int budget, input string name);
    int k;
    k = 0;
    while (!(mphase == ph && mg == port) && k < budget) begin
      cyc(1);
      k++;
    end
    chk(name, 80'(mphase == ph && mg == port), 80'(1));
  endtask

  int exp_rr[5] = '{0, 1, 2, 3, 0};
  int exp_mk[4] = '{1, 3, 1, 3};

  initial begin
    rst = 1'b1; port_enable = '0; gen_en = '0; gen_pct = 0; gap_pct = 0;
    lenc = 0; lenp = 0; cready_mode = 0; pready_mode = 0;
    repeat (3) @(posedge clk);
    #2;

    // Single port: 2-beat context, 4-beat payload
    setup(4'b1111, 4'b0001, 2, 4, 0);
    wait_pkts(1, 200, "single_done");
    chk("single_count", 80'(pkt_count), 80'(8'h01));
    chk("single_active", 80'(active_port), 80'(0));

    // All ports requesting: round-robin order
    setup(4'b1111, 4'b1111, 0, 0, 0);
    wait_pkts(5, 400, "rr_done");
    chk("rr_log_size", 80'(grant_log.size() >= 5), 80'(1));
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size()) chk("rr_order", 80'(grant_log[i]), 80'(exp_rr[i]));
    chk("rr_counts", 80'(pkt_count), 80'(8'h56));

    // Enable mask 1010: only ports 1 and 3 alternate
    setup(4'b1010, 4'b1111, 0, 0, 0);
    wait_pkts(4, 400, "mask_done");
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) chk("mask_order", 80'(grant_log[i]), 80'(exp_mk[i]));
    chk("mask_counts", 80'(pkt_count), 80'(8'h88));

    // Payload backpressure toggling during an 8-beat payload
    setup(4'b1111, 4'b0001, 1, 8, 1);
    wait_pkts(2, 200, "bp_done");
    chk("bp_count", 80'(pkt_count), 80'(8'h02));

    // Mask cleared during port 1 payload: packet completes, no regrant
    setup(4'b1111, 4'b0010, 2, 6, 0);
    wait_phase(2, 1, 100, "mask_pyld_reached");
    port_enable = 4'b1101;
    wait_pkts(1, 100, "mask_mid_done");
    cyc(30);
    chk("mask_mid_grants", 80'(grant_log.size()), 80'(1));
    chk("mask_mid_count", 80'(pkt_count), 80'(8'h04));

    // Reset during a context phase
    setup(4'b1111, 4'b0100, 3, 0, 0);
    wait_pkts(2, 200, "pre_rst_done");
    wait_phase(1, 2, 100, "rst_ctxt_reached");
    chk("pre_rst_count", 80'(pkt_count), 80'(8'h20));
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rst_handshakes",
        80'({m_context_tvalid, m_payload_tvalid, s_context_tready, s_payload_tready}), 80'(0));
    chk("rst_count", 80'(pkt_count), 80'(0));
    chk("rst_active", 80'(active_port), 80'(0));

    // Counter wrap with a 2-bit counter
    setup(4'b1111, 4'b0001, 0, 0, 0);
    wait_pkts(5, 500, "wrap_done");
    chk("wrap_count", 80'(pkt_count), 80'(8'h01));

    // Randomized traffic, mask churn and occasional resets
    setup(4'b1111, 4'b1111, 0, 0, 2);
    gen_pct = 40; gap_pct = 25; cready_mode = 1;
    for (int it = 0; it < 30; it++) begin
      port_enable = NP'($urandom);
      gen_en = NP'($urandom) | NP'(1 << (it % NP));
      if (it % 10 == 9) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
      cyc(100);
    end
    chk("random_progress", 80'(pkts_done > 20), 80'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
